// File: rtl/layer_input_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_input_buffer_pkg
// Description : Shared state encoding and width helper for the layer
//               hand-off buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_input_buffer_pkg;

    // FILL: collecting neuron results. FULL: contents frozen for next layer.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Address width for n entries; never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : layer_input_buffer_pkg
`default_nettype wire

// File: rtl/layer_input_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_input_buffer_if
// Description : Write/read/hand-off signal bundle between layer N neurons,
//               the input buffer and layer N+1's neuron controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_input_buffer_if #(
    parameter int CLOG2_NUM_ENTRIES = 1,
    parameter int DATA_WIDTH        = 8
);
    logic                         clk_en;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        in_data;
    logic [CLOG2_NUM_ENTRIES-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         layer_valid;
    logic                         consumer_done;
    logic [CLOG2_NUM_ENTRIES-1:0] wr_ptr;
    logic                         overflow;

    // Producer/consumer side: drives writes, read address and release.
    modport master (
        output clk_en, in_ready, in_data, rd_addr, consumer_done,
        input  rd_data, layer_valid, wr_ptr, overflow
    );

    // Buffer side.
    modport slave (
        input  clk_en, in_ready, in_data, rd_addr, consumer_done,
        output rd_data, layer_valid, wr_ptr, overflow
    );
endinterface : layer_input_buffer_if
`default_nettype wire

// File: rtl/layer_input_buffer_entry_counter.sv
`default_nettype none
// ============================================================================
// Module      : layer_input_buffer_entry_counter
// Description : Write-slot counter with enable and synchronous active-low
//               clear; write-side twin of the neuron address counter.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_input_buffer_entry_counter #(
    parameter int WIDTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,       // synchronous, active-low
    input  wire logic             clk_en_i,
    input  wire logic             clr_n_i,   // synchronous clear, active-low
    input  wire logic             inc_i,
    output logic [WIDTH-1:0]      count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (!clr_n_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register; reset is independent of the clock enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clk_en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : layer_input_buffer_entry_counter
`default_nettype wire

// File: rtl/layer_input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : layer_input_buffer
// Description : Collects one layer's neuron results into a register file and
//               serves them to the next layer once full, with a release
//               handshake and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_input_buffer
    import layer_input_buffer_pkg::*;
#(
    parameter int NUM_ENTRIES       = 2,
    parameter int CLOG2_NUM_ENTRIES = clog2_min1(NUM_ENTRIES),
    parameter int DATA_WIDTH        = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,   // synchronous, active-low
    layer_input_buffer_if.slave   bus
);

    // One extra counter bit so a power-of-two depth never aliases at wrap.
    localparam int                   c_CNT_W = CLOG2_NUM_ENTRIES + 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(NUM_ENTRIES - 1);

    state_e                  state_q;
    logic                    layer_valid_q;
    logic                    overflow_q;
    logic [DATA_WIDTH-1:0]   mem_q [NUM_ENTRIES];
    logic [c_CNT_W-1:0]      cnt;
    logic                    accept;
    logic                    at_last;
    logic [DATA_WIDTH-1:0]   rd_sel;

    // A sample is stored when filling, or when a release coincides with it
    // (the release wins, so the sample becomes entry 0 of the next fill).
    assign accept  = bus.clk_en & bus.in_ready &
                     ((state_q == FILL) | bus.consumer_done);
    assign at_last = (cnt == c_LAST);

    // In FULL the counter already sits at 0, so a plain release needs no
    // counter action and a release-with-write just increments.
    layer_input_buffer_entry_counter #(
        .WIDTH (c_CNT_W)
    ) u_entry_counter (
        .clk      (clk),
        .rst      (rst),
        .clk_en_i (bus.clk_en),
        .clr_n_i  (~(accept & at_last)),
        .inc_i    (accept & ~at_last),
        .count_o  (cnt)
    );

    // FILL/FULL control with registered layer_valid and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FILL;
            layer_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else if (bus.clk_en) begin
            unique case (state_q)
                FILL: begin
                    if (accept && at_last) begin
                        state_q       <= FULL;
                        layer_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.consumer_done) begin
                        // Single-entry buffer refills instantly on a
                        // release-with-write.
                        if (!(accept && at_last)) begin
                            state_q       <= FILL;
                            layer_valid_q <= 1'b0;
                        end
                    end else if (bus.in_ready) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= FILL;
                    layer_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Register file write: only the slot addressed by the counter updates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cnt == c_CNT_W'(i)) begin
                    mem_q[i] <= bus.in_data;
                end
            end
        end
    end

    // Zero-latency read mux; addresses beyond the depth return zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if ({1'b0, bus.rd_addr} == c_CNT_W'(i)) begin
                rd_sel = mem_q[i];
            end
        end
    end

    assign bus.rd_data     = rd_sel;
    assign bus.wr_ptr      = cnt[CLOG2_NUM_ENTRIES-1:0];
    assign bus.layer_valid = layer_valid_q;
    assign bus.overflow    = overflow_q;

endmodule : layer_input_buffer
`default_nettype wire

// File: doc/layer_input_buffer.md
# layer_input_buffer

Collects the scalar results produced by one layer's neurons, one `ready` pulse at a time, into a small register file. Once all results are collected, it serves them as the read-side responder for the next layer's neuron address counter. It sits between layer N's neuron outputs and layer N+1's neurons and provides the hand-off handshake between the two layers.

## Interface
- `NUM_ENTRIES`, default 2: number of neuron results per layer, which is also the next layer's input count.
- `CLOG2_NUM_ENTRIES`, default 1: address width; equals ceil(log2(NUM_ENTRIES)), minimum 1.
- `DATA_WIDTH`, default 8: width of one neuron result.
- `clk` input, 1 bit: clock; the only clock in the block.
- `rst` input, 1 bit: reset, synchronous and active-low.
- `clk_en` input, 1 bit: clock enable; all state holds when low.
- `in_ready` input, 1 bit: one-cycle pulse from a producing neuron marking `in_data` valid.
- `in_data` input, `DATA_WIDTH` bits: neuron result.
- `rd_addr` input, `CLOG2_NUM_ENTRIES` bits: read address from the next layer's neuron controller.
- `rd_data` output, `DATA_WIDTH` bits: entry at `rd_addr`.
- `layer_valid` output, 1 bit: buffer full; contents are stable and may be consumed.
- `consumer_done` input, 1 bit: the next layer has finished with the buffer; release it.
- `wr_ptr` output, `CLOG2_NUM_ENTRIES` bits: next write slot, for debug and verification.
- `overflow` output, 1 bit: sticky flag; a write was attempted while the buffer was full.

## Operation
- Two states: FILL and FULL. Reset enters FILL.
- Every action below requires `clk_en` = 1. When `clk_en` is 0, all registers hold and the inputs are ignored.
- **FILL, on `in_ready`:**
  - mem[`wr_ptr`] <= `in_data`.
  - If `wr_ptr` == NUM_ENTRIES-1: `wr_ptr` <= 0 and the state goes to FULL.
  - Otherwise `wr_ptr` increments by 1. No wrap occurs mid-fill.
- **FILL, on `consumer_done`:** ignored.
- **FULL:**
  - `layer_valid` = 1 and the memory is frozen.
  - `in_ready` alone sets `overflow` to 1; the data is dropped and `wr_ptr` is unchanged.
- **FULL, on `consumer_done`:**
  - The state goes to FILL and `wr_ptr` is 0.
  - If `in_ready` is also 1 in the same cycle, the release wins and the sample is accepted: mem[0] <= `in_data` and `wr_ptr` <= 1. If NUM_ENTRIES == 1, the state goes straight back to FULL instead.
  - `overflow` is not set in this case.
- **Read path:**
  - `rd_data` = mem[`rd_addr`], combinational, in both states.
  - If `rd_addr` >= NUM_ENTRIES, `rd_data` = 0.
- `overflow` is cleared only by reset.
- **Reset (`rst` = 0 at a clock edge):**
  - State is FILL, `wr_ptr` = 0, `layer_valid` = 0, `overflow` = 0, and every mem entry is 0. As a result `rd_data` reads 0.
  - Reset takes effect regardless of `clk_en` and aborts a partial fill.
- **Width rules:** all counter compares use `CLOG2_NUM_ENTRIES`+1 bits. This keeps NUM_ENTRIES equal to a power of two exact, with no aliasing at wrap.

## Timing
- Write to readback latency is 1 cycle: data written at edge k is visible on `rd_data` after edge k.
- `layer_valid` rises in the cycle after the edge that writes the last entry.
- `layer_valid` falls in the cycle after the edge that samples `consumer_done`.
- Minimum fill time is NUM_ENTRIES cycles, with back-to-back `in_ready` pulses allowed in consecutive cycles.
- `layer_valid` and `overflow` are registered outputs, with no combinational path from any input.
- `rd_data` depends combinationally on `rd_addr`. Its read-to-data latency is 0 cycles, so that the neuron controller's address lines up with its MAC cycle.

## Structure
- A shared package holds the state encoding (FILL = 1'b0, FULL = 1'b1) and a clog2 helper constant function.
- Natural sub-module: `entry_counter`, a `CLOG2_NUM_ENTRIES`+1 bit counter with enable and a synchronous active-low clear. It is the write-side twin of the neuron address counter.
- The register file stays inline: NUM_ENTRIES x DATA_WIDTH flops with a read mux.

## Test plan
- **Basic fill and readback:** NUM_ENTRIES=4, DATA_WIDTH=8.
  - Stimulus: pulse `in_ready` on 4 consecutive cycles with 0x11, 0x22, 0x33, 0x44.
  - Required: `layer_valid`=1 one cycle after the 4th write; `rd_addr` 0..3 returns 0x11..0x44; `wr_ptr`=0.
- **Overflow while full:**
  - Stimulus: with the buffer full, pulse `in_ready` with 0x99.
  - Required: `overflow`=1 next cycle; mem[0] is still 0x11; `wr_ptr`=0.
- **Release with a simultaneous write:**
  - Stimulus: while full, assert `consumer_done` and `in_ready` (0x55) in the same cycle.
  - Required: `layer_valid`=0, mem[0]=0x55, `wr_ptr`=1, `overflow` unchanged.
- **clk_en gating:**
  - Stimulus: hold `clk_en`=0 while pulsing `in_ready` and `consumer_done`.
  - Required: no change to `wr_ptr`, mem, or state.
- **Reset mid-fill:**
  - Stimulus: after 2 writes, drive `rst`=0 for 1 cycle (with `clk_en`=0).
  - Required: `wr_ptr`=0, `layer_valid`=0, `overflow`=0, `rd_data`=0 for every address.
- **Power-of-two boundary:** NUM_ENTRIES=2, CLOG2_NUM_ENTRIES=1.
  - Stimulus: 2 writes.
  - Required: FULL after exactly 2 writes with no premature wrap; `rd_addr`=1 returns the second value.
